// File: rtl/hv_core_sequencer.sv
// Job sequencer for one hypervector core: item generation, credit-throttled
// instruction streaming, and buffering of store results into an output FIFO.
module hv_core_sequencer #(
    parameter int DIM       = 1023,
    parameter int OUT_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [10:0]     item_num,
    output logic            busy,
    output logic            done,
    input  logic            inst_valid,
    input  logic [15:0]     inst_data,
    output logic            inst_ready,
    output logic            core_run,
    output logic            core_gen,
    output logic            core_update_item,
    output logic [9:0]      core_item_a,
    output logic            core_get_v,
    output logic [15:0]     core_get_d,
    output logic            core_exec,
    input  logic            core_store,
    input  logic [DIM:0]    core_result,
    input  logic            core_last,
    output logic            out_valid,
    output logic [DIM:0]    out_data,
    input  logic            out_ready
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, GEN, EXEC, DRAIN, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [10:0]     item_num_q;
    logic [9:0]      item_cnt;
    logic            last_taken;
    logic [CW-1:0]   pending_stores;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [DIM:0]    fifo_mem [OUT_DEPTH];

    logic            inst_fire;
    logic            inst_is_store;
    logic            inst_is_last;
    logic            gen_last;
    logic            credit_ok;
    logic [CW:0]     credit_used;
    logic            fifo_wr;
    logic            fifo_rd;
    logic            store_ret;

    assign inst_is_store = !inst_data[15] && (inst_data[14:11] == 4'b0001);
    assign inst_is_last  = !inst_data[15] && (inst_data[14:10] == 5'b00001);
    assign inst_fire     = inst_valid && inst_ready;

    // Credit counts results still in flight inside the core, since its store port cannot stall.
    assign credit_used = {1'b0, fifo_count} + {1'b0, pending_stores};
    assign credit_ok   = credit_used < (CW + 1)'(OUT_DEPTH);

    assign gen_last  = ({1'b0, item_cnt} == (item_num_q - 11'd1));
    assign fifo_wr   = core_store && (state != IDLE);
    assign fifo_rd   = out_valid && out_ready;
    assign store_ret = fifo_wr && (pending_stores != '0);

    assign busy        = (state != IDLE);
    assign core_item_a = item_cnt;
    assign out_valid   = (fifo_count != '0);
    assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt        = state;
        core_run         = 1'b0;
        core_gen         = 1'b0;
        core_update_item = 1'b0;
        core_exec        = 1'b0;
        inst_ready       = 1'b0;
        done             = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (item_num == 11'd0) ? EXEC : GEN;
            end
            GEN: begin
                core_run         = 1'b1;
                core_gen         = 1'b1;
                core_update_item = 1'b1;
                if (gen_last) state_nxt = EXEC;
            end
            EXEC: begin
                core_run   = 1'b1;
                core_exec  = 1'b1;
                inst_ready = credit_ok && !last_taken;
                if (inst_fire && inst_is_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                core_run  = 1'b1;
                core_exec = 1'b1;
                if (core_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                core_run = 1'b1;
                if (fifo_count == '0 && pending_stores == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            item_num_q     <= '0;
            item_cnt       <= '0;
            last_taken     <= 1'b0;
            core_get_v     <= 1'b0;
            core_get_d     <= '0;
            pending_stores <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                item_num_q <= (item_num > 11'd1024) ? 11'd1024 : item_num;
                last_taken <= 1'b0;
            end
            if (state == GEN) item_cnt <= gen_last ? '0 : item_cnt + 10'd1;
            if (inst_fire && inst_is_last) last_taken <= 1'b1;
            // A cycle without a handshake presents an all-zero word, which the core executes as nop.
            core_get_v <= inst_fire;
            core_get_d <= inst_fire ? inst_data : '0;
            case ({inst_fire && inst_is_store, store_ret})
                2'b10:   pending_stores <= pending_stores + 1'b1;
                2'b01:   pending_stores <= pending_stores - 1'b1;
                default: pending_stores <= pending_stores;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                assert (fifo_count < CW'(OUT_DEPTH));
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; out_valid gates it, and out_data is forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= core_result;
    end

endmodule

// File: doc/hv_core_sequencer.md
Name: hv_core_sequencer

Overview:
Controller that sequences one hypervector core through a full job: item-memory generation, instruction streaming, and result collection. It owns the core's run/gen/update_item/item_a/get_v/get_d/exec inputs and buffers the core's store results in an output FIFO. Instruction issue is throttled on output credit, because the core's store output has no backpressure. It sits between the host instruction stream (DMA) and the core, and presents results as a valid/ready stream.

Parameters:
DIM, 1023, MSB index of a hypervector; vectors are DIM+1 bits.
OUT_DEPTH, 8, result FIFO depth in entries; minimum 4, power of two.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle job start pulse; ignored unless idle
item_num  in  11  items to generate (0..1024); sampled on accepted start
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at job completion
inst_valid  in  1  host instruction valid
inst_data  in  16  host 16-bit core instruction
inst_ready  out  1  sequencer accepts instruction
core_run  out  1  to core run
core_gen  out  1  to core gen
core_update_item  out  1  to core update_item
core_item_a  out  10  to core item_a
core_get_v  out  1  to core get_v
core_get_d  out  16  to core get_d
core_exec  out  1  to core exec
core_store  in  1  from core store
core_result  in  DIM+1  from core core_result
core_last  in  1  from core last
out_valid  out  1  result stream valid
out_data  out  DIM+1  result vector (FIFO head)
out_ready  in  1  result stream ready

Behaviour:
- Reset: state IDLE; all outputs 0; FIFO emptied; counters 0. Reset asserted mid-job aborts the job immediately. done is not pulsed.
- FSM: IDLE -> GEN -> EXEC -> DRAIN -> FLUSH -> IDLE.
- IDLE: start=1 latches item_num and moves to GEN, or directly to EXEC if item_num=0.
- GEN: core_run=1, core_gen=1, core_update_item=1, core_item_a=counter starting at 0 and incrementing each cycle. After the cycle with item_a=item_num-1, go to EXEC; item_num=1024 ends at 1023 with no wrap. GEN lasts exactly item_num cycles.
- EXEC: core_run=1, core_exec=1.
  - inst_ready = (fifo_count + pending_stores < OUT_DEPTH) && !last_taken.
  - inst_ready never depends on inst_data.
  - On a handshake, core_get_v=1 and core_get_d=inst_data are registered for the next cycle. Without a handshake, core_get_v=0 and core_get_d=0, which the core treats as nop.
- Store decode on an accepted word: bit15=0 and bits14:11=0001. It increments pending_stores; core_store=1 decrements it. Both in the same cycle leaves it unchanged.
- Last decode: bit15=0 and bits14:10=00001. Accepting a last sets last_taken and moves to DRAIN.
- DRAIN: core_run=1, core_exec=1, inst_ready=0. Wait for core_last=1, then go to FLUSH.
- FLUSH: core_run=1, core_exec=0. Wait until fifo_count=0 and pending_stores=0. Then pulse done for one cycle and return to IDLE with core_run=0.
- Latency: the handshake edge is E0. The core latches the instruction at E1. core_store=1 follows E2. The FIFO writes at E3, and out_valid=1 after E3, i.e. 3 edges after acceptance.
- FIFO:
  - Write when core_store=1 (data core_result); read when out_valid && out_ready.
  - Simultaneous read and write keeps the count unchanged.
  - out_valid = fifo_count != 0.
  - Overflow is impossible under the credit rule. A write when full is an assertion failure.
- core_store seen in IDLE is discarded.
- Widths: fifo_count and pending_stores are log2(OUT_DEPTH)+1 bits.

Test Plan:
- item_num=4, start -> core_gen/update_item high for 4 cycles with item_a=0,1,2,3; then EXEC with core_run=1.
- item_num=0 -> IDLE goes straight to EXEC; core_gen never asserted.
- Stream load, store, store, last with out_ready=1 -> two out_valid beats carrying core_result values. After core_last, FIFO empty, then done is a 1-cycle pulse and busy=0.
- out_ready=0, 10 store instructions, OUT_DEPTH=8 -> inst_ready drops after 8 stores accepted; no overflow. Raising out_ready yields all 10 results in order.
- Store accepted at E0 -> out_valid rises exactly after E3; pending_stores returns to 0.
- rst pulsed during EXEC with FIFO holding 3 entries -> all outputs 0 and FIFO empty immediately; no done pulse; the next start runs a clean job.
